// File: rtl/space_pkg.sv
// Shared screen, colour and bullet-geometry constants plus the enemy-row state type
// for the space-shooter video layers.
package space_pkg;

    localparam logic [10:0] SCREEN_W   = 11'd640;
    localparam logic [10:0] SCREEN_H   = 11'd480;
    localparam logic [10:0] WALL_L     = 11'd3;
    localparam logic [10:0] WALL_R     = 11'd636;
    localparam logic [10:0] TICK_LINE  = 11'd481;

    localparam logic [2:0]  COL_BLACK  = 3'b000;
    localparam logic [2:0]  COL_ENEMY  = 3'b010;

    // Bullet box relative to the bullet register: x = bull_x+3 .. +6, y = bull_y-5 .. bull_y
    localparam logic [10:0] BULL_OFF_X = 11'd3;
    localparam logic [10:0] BULL_W     = 11'd4;
    localparam logic [10:0] BULL_H     = 11'd6;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        CLEAR = 2'd1,
        OVER  = 2'd2
    } enemy_state_e;

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        sat_inc10 = (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/box_overlap.sv
// Combinational inclusive rectangle-overlap test between box a and box b
// (all coordinates 11-bit unsigned, both corners inclusive).
module box_overlap (
    input  logic [10:0] a_x0_i,
    input  logic [10:0] a_x1_i,
    input  logic [10:0] a_y0_i,
    input  logic [10:0] a_y1_i,
    input  logic [10:0] b_x0_i,
    input  logic [10:0] b_x1_i,
    input  logic [10:0] b_y0_i,
    input  logic [10:0] b_y1_i,
    output logic        overlap_o
);

    assign overlap_o = (a_x0_i <= b_x1_i) && (b_x0_i <= a_x1_i) &&
                       (a_y0_i <= b_y1_i) && (b_y0_i <= a_y1_i);

endmodule

// File: rtl/enemy_row.sv
// One marching row of invaders: movement, alive mask, bullet hits, score and wave/game-over FSM.
// Optional build macro ENEMY_SPEEDUP_EN shortens the move divider by one frame per cleared wave.
module enemy_row
    import space_pkg::*;
#(
    parameter int N_ENEMY        = 8,
    parameter int ENEMY_W        = 16,
    parameter int ENEMY_H        = 12,
    parameter int SPACING        = 32,
    parameter int ROW_X0         = 64,
    parameter int ROW_Y0         = 40,
    parameter int STEP_X         = 2,
    parameter int DROP_Y         = 8,
    parameter int MOVE_DIV       = 4,
    parameter int BULL_REST_Y    = 464,
    parameter int PLAYER_T       = 465,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               video_on,
    input  logic [10:0]        pix_x,
    input  logic [10:0]        pix_y,
    input  logic [10:0]        bull_x,
    input  logic [10:0]        bull_y,
    output logic               enemy_on,
    output logic [2:0]         rgb,
    output logic               hit,
    output logic [9:0]         score,
    output logic [3:0]         wave,
    output logic [N_ENEMY-1:0] alive,
    output logic               game_over
);

    localparam logic [10:0] RIGHT_SPAN = 11'((N_ENEMY - 1) * SPACING + ENEMY_W - 1);
    localparam logic [10:0] STEP       = 11'(STEP_X);
    localparam logic [10:0] DROP       = 11'(DROP_Y);

    logic [10:0]        row_x_q, row_x_d;
    logic [10:0]        row_y_q, row_y_d;
    logic               dir_q, dir_d;          // 1'b0 = moving right
    logic [7:0]         move_cnt_q, move_cnt_d;
    logic [7:0]         resp_cnt_q, resp_cnt_d;
    logic [N_ENEMY-1:0] alive_q, alive_d;
    logic [9:0]         score_q, score_d;
    logic [3:0]         wave_q, wave_d;
    logic               hit_q, hit_d;
    logic               game_over_q, game_over_d;
    enemy_state_e       state_q, state_d;

    logic               frame_tick_s;
    logic               in_flight_s;
    logic [7:0]         div_s;
    logic [10:0]        bx0_s, bx1_s, by0_s, by1_s, ey1_s;
    logic [10:0]        ex0_s [N_ENEMY];
    logic [10:0]        ex1_s [N_ENEMY];
    logic [N_ENEMY-1:0] ovl_s, pix_in_s, cand_s, kill_mask_s;

    assign frame_tick_s = (pix_y == TICK_LINE) && (pix_x == 11'd0);
    assign in_flight_s  = bull_y < 11'(BULL_REST_Y);

    assign bx0_s = bull_x + BULL_OFF_X;
    assign bx1_s = bx0_s + BULL_W - 11'd1;
    assign by1_s = bull_y;
    assign by0_s = bull_y - (BULL_H - 11'd1);
    assign ey1_s = row_y_q + 11'(ENEMY_H - 1);

`ifdef ENEMY_SPEEDUP_EN
    assign div_s = (8'(MOVE_DIV) > {4'd0, wave_q}) ? (8'(MOVE_DIV) - {4'd0, wave_q}) : 8'd1;
`else
    assign div_s = 8'(MOVE_DIV);
`endif

    for (genvar gi = 0; gi < N_ENEMY; gi++) begin : g_enemy
        assign ex0_s[gi]    = row_x_q + 11'(gi * SPACING);
        assign ex1_s[gi]    = ex0_s[gi] + 11'(ENEMY_W - 1);
        assign pix_in_s[gi] = (pix_x >= ex0_s[gi]) && (pix_x <= ex1_s[gi]) &&
                              (pix_y >= row_y_q) && (pix_y <= ey1_s);

        box_overlap u_ovl (
            .a_x0_i    (ex0_s[gi]),
            .a_x1_i    (ex1_s[gi]),
            .a_y0_i    (row_y_q),
            .a_y1_i    (ey1_s),
            .b_x0_i    (bx0_s),
            .b_x1_i    (bx1_s),
            .b_y0_i    (by0_s),
            .b_y1_i    (by1_s),
            .overlap_o (ovl_s[gi])
        );
    end

    // Isolate the lowest set bit so at most one enemy dies per frame
    assign cand_s      = alive_q & ovl_s & {N_ENEMY{in_flight_s}};
    assign kill_mask_s = cand_s & (~cand_s + {{(N_ENEMY-1){1'b0}}, 1'b1});

    assign enemy_on  = (state_q != CLEAR) && ((pix_in_s & alive_q) != '0);
    assign rgb       = (enemy_on && video_on) ? COL_ENEMY : COL_BLACK;
    assign hit       = hit_q;
    assign score     = score_q;
    assign wave      = wave_q;
    assign alive     = alive_q;
    assign game_over = game_over_q;

    // Next-state logic: all updates gated by the frame tick; kill uses pre-move positions
    always_comb begin
        row_x_d    = row_x_q;
        row_y_d    = row_y_q;
        dir_d      = dir_q;
        move_cnt_d = move_cnt_q;
        resp_cnt_d = resp_cnt_q;
        alive_d    = alive_q;
        score_d    = score_q;
        wave_d     = wave_q;
        hit_d      = 1'b0;
        state_d    = state_q;
        case (state_q)
            PLAY: begin
                if (frame_tick_s) begin
                    alive_d = alive_q & ~kill_mask_s;
                    if (kill_mask_s != '0) begin
                        hit_d   = 1'b1;
                        score_d = sat_inc10(score_q);
                    end else begin
                        hit_d   = 1'b0;
                    end
                    if (move_cnt_q >= div_s - 8'd1) begin
                        move_cnt_d = 8'd0;
                        if (!dir_q && (row_x_q + RIGHT_SPAN + STEP) > WALL_R) begin
                            dir_d   = 1'b1;
                            row_y_d = row_y_q + DROP;
                        end else if (dir_q && (row_x_q < WALL_L + STEP)) begin
                            dir_d   = 1'b0;
                            row_y_d = row_y_q + DROP;
                        end else if (!dir_q) begin
                            row_x_d = row_x_q + STEP;
                        end else begin
                            row_x_d = row_x_q - STEP;
                        end
                    end else begin
                        move_cnt_d = move_cnt_q + 8'd1;
                    end
                    if (alive_d == '0) begin
                        state_d = CLEAR;
                        wave_d  = wave_q + 4'd1;
                    end else if ((row_y_d + 11'(ENEMY_H - 1)) >= 11'(PLAYER_T)) begin
                        state_d = OVER;
                    end else begin
                        state_d = PLAY;
                    end
                end else begin
                    state_d = PLAY;
                end
            end
            CLEAR: begin
                if (frame_tick_s) begin
                    if (resp_cnt_q == 8'(RESPAWN_FRAMES - 1)) begin
                        alive_d    = '1;
                        row_x_d    = 11'(ROW_X0);
                        row_y_d    = 11'(ROW_Y0);
                        dir_d      = 1'b0;
                        resp_cnt_d = 8'd0;
                        state_d    = PLAY;
                    end else begin
                        resp_cnt_d = resp_cnt_q + 8'd1;
                    end
                end else begin
                    state_d = CLEAR;
                end
            end
            OVER: begin
                state_d = OVER;
            end
            default: begin
                state_d = PLAY;
            end
        endcase
        game_over_d = (state_d == OVER);
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            row_x_q     <= 11'(ROW_X0);
            row_y_q     <= 11'(ROW_Y0);
            dir_q       <= 1'b0;
            move_cnt_q  <= 8'd0;
            resp_cnt_q  <= 8'd0;
            alive_q     <= '1;
            score_q     <= 10'd0;
            wave_q      <= 4'd0;
            hit_q       <= 1'b0;
            game_over_q <= 1'b0;
            state_q     <= PLAY;
        end else begin
            row_x_q     <= row_x_d;
            row_y_q     <= row_y_d;
            dir_q       <= dir_d;
            move_cnt_q  <= move_cnt_d;
            resp_cnt_q  <= resp_cnt_d;
            alive_q     <= alive_d;
            score_q     <= score_d;
            wave_q      <= wave_d;
            hit_q       <= hit_d;
            game_over_q <= game_over_d;
            state_q     <= state_d;
        end
    end

endmodule

// File: tb/tb_enemy_row.sv
// Self-checking bench for enemy_row: a behavioural row model pushes expected status per frame
// tick into a scoreboard queue; pixel probes check row position against fixed coordinates.
module tb_enemy_row;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        video_on = 1'b1;
    logic [10:0] pix_x = 11'd0;
    logic [10:0] pix_y = 11'd0;
    logic [10:0] bull_x = 11'd0;
    logic [10:0] bull_y = 11'd464;
    logic        enemy_on;
    logic [2:0]  rgb;
    logic        hit;
    logic [9:0]  score;
    logic [3:0]  wave;
    logic [7:0]  alive;
    logic        game_over;

    enemy_row dut (
        .clk(clk), .reset(reset), .video_on(video_on), .pix_x(pix_x), .pix_y(pix_y),
        .bull_x(bull_x), .bull_y(bull_y), .enemy_on(enemy_on), .rgb(rgb), .hit(hit),
        .score(score), .wave(wave), .alive(alive), .game_over(game_over)
    );

    initial forever #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    logic [23:0] sb_q[$];

    // Behavioural model state (state: 0 PLAY, 1 CLEAR, 2 OVER; dir: 0 right)
    int m_x, m_y, m_dir, m_cnt, m_resp, m_state;
    logic [7:0] m_alive;
    logic [9:0] m_score;
    logic [3:0] m_wave;
    logic       m_hit;

    function automatic logic [23:0] obs();
        return {alive, score, wave, game_over, hit};
    endfunction

    function automatic int low_alive();
        for (int i = 0; i < 8; i++) if (m_alive[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_x = 64; m_y = 40; m_dir = 0; m_cnt = 0; m_resp = 0; m_state = 0;
        m_alive = 8'hFF; m_score = 10'd0; m_wave = 4'd0; m_hit = 1'b0;
        sb_q.delete();
    endtask

    task automatic model_tick(input int bx, input int by);
        int div;
        m_hit = 1'b0;
        if (m_state == 0) begin
            if (by < 464) begin
                for (int i = 0; i < 8; i++) begin
                    if (!m_hit && m_alive[i] && (bx + 6 >= m_x + 32 * i) && (bx + 3 <= m_x + 32 * i + 15)
                        && (by >= m_y) && (by - 5 <= m_y + 11)) begin
                        m_alive[i] = 1'b0;
                        m_hit = 1'b1;
                        if (m_score != 10'd1023) m_score = m_score + 10'd1;
                    end
                end
            end
            div = 4;
`ifdef ENEMY_SPEEDUP_EN
            div = (4 - int'(m_wave) < 1) ? 1 : 4 - int'(m_wave);
`endif
            if (m_cnt >= div - 1) begin
                m_cnt = 0;
                if (m_dir == 0 && m_x + 239 + 2 > 636) begin m_dir = 1; m_y += 8; end
                else if (m_dir == 1 && m_x < 5) begin m_dir = 0; m_y += 8; end
                else if (m_dir == 0) m_x += 2;
                else m_x -= 2;
            end else begin
                m_cnt++;
            end
            if (m_alive == 8'h00) begin m_state = 1; m_wave = m_wave + 4'd1; end
            else if (m_y + 11 >= 465) m_state = 2;
        end else if (m_state == 1) begin
            if (m_resp == 59) begin
                m_alive = 8'hFF; m_x = 64; m_y = 40; m_dir = 0; m_resp = 0; m_state = 0;
            end else begin
                m_resp++;
            end
        end
        sb_q.push_back({m_alive, m_score, m_wave, (m_state == 2), m_hit});
    endtask

    // One frame tick: entered and left on a falling clock edge
    task automatic do_tick(input int bx, input int by);
        bull_x = 11'(bx); bull_y = 11'(by);
        pix_x = 11'd0; pix_y = 11'd481;
        model_tick(bx, by);
        @(negedge clk);
        pix_y = 11'd0;
    endtask

    task automatic probe(input int x, input int y, output logic on);
        pix_x = 11'(x); pix_y = 11'(y);
        #1 on = enemy_on;
        @(negedge clk);
    endtask

    task automatic test_reset(input string tag);
        logic on;
        int pts[5][3] = '{'{64, 40, 1}, '{63, 40, 0}, '{79, 51, 1}, '{80, 40, 0}, '{64, 52, 0}};
        @(negedge clk);
        pix_x = 11'd0; pix_y = 11'd0; bull_y = 11'd464;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        n_total++;
        if (obs() !== {8'hFF, 10'd0, 4'd0, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL reset_state(%s): got=%h exp=%h", tag, obs(), {8'hFF, 10'd0, 4'd0, 1'b0, 1'b0});
        end
        for (int k = 0; k < 5; k++) begin
            probe(pts[k][0], pts[k][1], on);
            n_total++;
            if (on !== pts[k][2][0]) begin
                n_bad++; $display("FAIL reset_pix(%s) (%0d,%0d): got=%b exp=%b", tag, pts[k][0], pts[k][1], on, pts[k][2][0]);
            end
        end
        pix_x = 11'd64; pix_y = 11'd40; video_on = 1'b1;
        #1 n_total++;
        if (rgb !== 3'b010) begin n_bad++; $display("FAIL rgb_on: got=%b exp=010", rgb); end
        video_on = 1'b0;
        #1 n_total++;
        if (rgb !== 3'b000) begin n_bad++; $display("FAIL rgb_blank: got=%b exp=000", rgb); end
        video_on = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_march();
        logic on;
        logic [23:0] e;
        for (int k = 0; k < 4; k++) begin
            do_tick(0, 464);
            e = sb_q.pop_front(); n_total++;
            if (obs() !== e) begin n_bad++; $display("FAIL march_tick%0d: got=%h exp=%h", k, obs(), e); end
        end
        probe(66, 40, on); n_total++;
        if (on !== 1'b1) begin n_bad++; $display("FAIL march_x66: got=%b exp=1", on); end
        probe(65, 40, on); n_total++;
        if (on !== 1'b0) begin n_bad++; $display("FAIL march_x65: got=%b exp=0", on); end
    endtask

    task automatic test_hit();
        logic [23:0] e;
        do_tick(61, 50);
        e = sb_q.pop_front(); n_total++;
        if (obs() !== e) begin n_bad++; $display("FAIL hit_sb: got=%h exp=%h", obs(), e); end
        n_total++;
        if (alive !== 8'hFE || hit !== 1'b1 || score !== 10'd1) begin
            n_bad++; $display("FAIL hit_kill0: alive=%h hit=%b score=%0d exp FE/1/1", alive, hit, score);
        end
        @(negedge clk); n_total++;
        if (hit !== 1'b0) begin n_bad++; $display("FAIL hit_pulse_len: got=%b exp=0", hit); end
        do_tick(61, 50);
        e = sb_q.pop_front(); n_total++;
        if (obs() !== e || hit !== 1'b0 || score !== 10'd1) begin
            n_bad++; $display("FAIL hit_repeat: got=%h exp=%h", obs(), e);
        end
    endtask

    task automatic test_boundaries();
        logic [23:0] e;
        int cs[9][2] = '{'{-7, 5}, '{13, 5}, '{16, 5}, '{0, -1}, '{0, 17}, '{0, 999},
                         '{-6, 5}, '{12, 5}, '{0, 16}};
        int x0, by;
        for (int k = 0; k < 9; k++) begin
            x0 = m_x + 32 * low_alive();
            by = (cs[k][1] == 999) ? 464 : m_y + cs[k][1];
            do_tick(x0 + cs[k][0], by);
            e = sb_q.pop_front(); n_total++;
            if (obs() !== e) begin n_bad++; $display("FAIL bound_case%0d: got=%h exp=%h", k, obs(), e); end
        end
        n_total++;
        if (alive !== 8'hF0 || score !== 10'd4) begin
            n_bad++; $display("FAIL bound_total: alive=%h score=%0d exp F0/4", alive, score);
        end
    endtask

    task automatic test_edge_bounce();
        logic on;
        logic [23:0] e;
        int guard = 0;
        int pts[4][3] = '{'{620, 48, 1}, '{635, 48, 1}, '{636, 48, 0}, '{620, 47, 0}};
        while (m_dir == 0 && guard < 3000) begin
            do_tick(0, 464);
            e = sb_q.pop_front(); n_total++;
            if (obs() !== e) begin n_bad++; $display("FAIL edge_tick%0d: got=%h exp=%h", guard, obs(), e); end
            guard++;
        end
        n_total++;
        if (guard >= 3000) begin n_bad++; $display("FAIL edge_timeout: got=%0d ticks exp <3000", guard); end
        for (int k = 0; k < 4; k++) begin
            probe(pts[k][0], pts[k][1], on); n_total++;
            if (on !== pts[k][2][0]) begin
                n_bad++; $display("FAIL edge_pix (%0d,%0d): got=%b exp=%b", pts[k][0], pts[k][1], on, pts[k][2][0]);
            end
        end
    endtask

    task automatic test_clear_respawn();
        logic on;
        logic [23:0] e;
        int guard = 0;
        int pts[4][3] = '{'{64, 40, 1}, '{63, 40, 0}, '{64, 39, 0}, '{288, 40, 1}};
        while (m_alive != 8'h00 && guard < 20) begin
            do_tick(m_x + 32 * low_alive(), m_y + 5);
            e = sb_q.pop_front(); n_total++;
            if (obs() !== e) begin n_bad++; $display("FAIL clear_kill%0d: got=%h exp=%h", guard, obs(), e); end
            guard++;
        end
        n_total++;
        if (alive !== 8'h00 || wave !== 4'd1 || score !== 10'd8 || game_over !== 1'b0) begin
            n_bad++; $display("FAIL clear_enter: alive=%h wave=%0d score=%0d go=%b exp 00/1/8/0", alive, wave, score, game_over);
        end
        probe(m_x + 224, m_y, on); n_total++;
        if (on !== 1'b0) begin n_bad++; $display("FAIL clear_hidden: got=%b exp=0", on); end
        for (int k = 0; k < 60; k++) begin
            if (k == 59) begin
                n_total++;
                if (alive !== 8'h00) begin n_bad++; $display("FAIL clear_early: got=%h exp=00", alive); end
            end
            do_tick(0, 464);
            e = sb_q.pop_front(); n_total++;
            if (obs() !== e) begin n_bad++; $display("FAIL clear_tick%0d: got=%h exp=%h", k, obs(), e); end
        end
        n_total++;
        if (alive !== 8'hFF || score !== 10'd8 || wave !== 4'd1) begin
            n_bad++; $display("FAIL respawn: alive=%h score=%0d wave=%0d exp FF/8/1", alive, score, wave);
        end
        for (int k = 0; k < 4; k++) begin
            probe(pts[k][0], pts[k][1], on); n_total++;
            if (on !== pts[k][2][0]) begin
                n_bad++; $display("FAIL respawn_pix (%0d,%0d): got=%b exp=%b", pts[k][0], pts[k][1], on, pts[k][2][0]);
            end
        end
    endtask

    task automatic test_game_over();
        logic on;
        logic [23:0] e;
        int guard = 0;
        while (m_state != 2 && guard < 60000) begin
            do_tick(0, 464);
            e = sb_q.pop_front(); n_total++;
            if (obs() !== e) begin n_bad++; $display("FAIL over_run%0d: got=%h exp=%h", guard, obs(), e); end
            guard++;
        end
        n_total++;
        if (guard >= 60000) begin n_bad++; $display("FAIL over_timeout: got=%0d ticks exp <60000", guard); end
        n_total++;
        if (game_over !== 1'b1 || alive !== 8'hFF) begin
            n_bad++; $display("FAIL over_flag: go=%b alive=%h exp 1/FF", game_over, alive);
        end
        for (int k = 0; k < 6; k++) begin
            do_tick(m_x, 460);
            e = sb_q.pop_front(); n_total++;
            if (obs() !== e || hit !== 1'b0) begin n_bad++; $display("FAIL over_frozen%0d: got=%h exp=%h", k, obs(), e); end
        end
        probe(m_x + 224, 456, on); n_total++;
        if (on !== 1'b1) begin n_bad++; $display("FAIL over_drawn: got=%b exp=1", on); end
        probe(m_x + 224, 455, on); n_total++;
        if (on !== 1'b0) begin n_bad++; $display("FAIL over_row_y: got=%b exp=0", on); end
    endtask

    initial begin
        test_reset("power_on");
        test_march();
        test_hit();
        test_boundaries();
        test_edge_bounce();
        test_clear_respawn();
        test_game_over();
        test_reset("after_over");
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
